// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the fetch stage.
//
// Holds the architectural fetch PC and issues one instruction-memory request
// at a time. It tracks the single outstanding response and squashes it if a
// branch/jump redirect arrives while the request is in flight. Fetched
// instructions are presented to decode as a valid/stall-held packet.
//
// Ports:
//   clk, rst        - clock (rising edge) / asynchronous active-high reset
//   stall_i         - decode cannot accept; hold the current packet
//   redirect_i      - branch/jump taken; restart fetch at redirect_pc_i
//   redirect_pc_i   - redirect target (bits [1:0] forced to zero)
//   mem_req_o       - fetch request valid
//   mem_addr_o      - word-aligned fetch address
//   mem_gnt_i       - memory accepted the request this cycle
//   mem_rvalid_i    - read data valid for the outstanding request
//   mem_rdata_i     - fetched instruction word
//   inst_valid_o    - inst_o / inst_pc_o valid
//   inst_o          - fetched instruction
//   inst_pc_o       - PC of inst_o
module fetch_ctrl #(
    parameter int unsigned           XLEN      = 32,
    parameter int unsigned           ILEN      = 32,
    parameter logic [XLEN-1:0]       BOOT_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [ILEN-1:0] mem_rdata_i,
    output logic            inst_valid_o,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            kill;   // outstanding response belongs to a squashed path
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};

    // Request outputs are decoded from registered state only, so the address
    // is stable for the whole REQ phase and a redirect shows up one cycle
    // later as the new pc.
    assign mem_req_o  = (state == REQ);
    assign mem_addr_o = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= BOOT_ADDR;
            req_pc       <= '0;
            kill         <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
        end else if (redirect_i) begin
            // Redirect beats every normal transition; the packet is dropped
            // and any response still owed by memory is marked for discard.
            pc           <= redirect_target;
            inst_valid_o <= 1'b0;
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (mem_gnt_i) begin
                        req_pc <= pc;
                        kill   <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        // Response arrives with the redirect: consume and drop it.
                        kill  <= 1'b0;
                        state <= REQ;
                    end else begin
                        kill  <= 1'b1;
                    end
                end
                VALID: state <= REQ;
                default: state <= BOOT;
            endcase
        end else begin
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (mem_gnt_i) begin
                        req_pc <= pc;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        if (kill) begin
                            // pc already holds the redirect target.
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            inst_o       <= mem_rdata_i;
                            inst_pc_o    <= req_pc;
                            inst_valid_o <= 1'b1;
                            pc           <= req_pc + XLEN'(4);
                            state        <= VALID;
                        end
                    end
                end
                VALID: begin
                    if (!stall_i) begin
                        inst_valid_o <= 1'b0;
                        state        <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl. Inputs change and outputs are
// sampled on the falling clock edge; the DUT updates on the rising edge.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    int unsigned total  = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .XLEN      (32),
        .ILEN      (32),
        .BOOT_ADDR (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Memory content for a given address, fixed by the bench.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA5A5_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_1357;
    endfunction

    // From a falling edge in REQ: check the request, grant at once, return
    // data the next cycle, and check the packet. Ends in VALID.
    task automatic serve(input string tag, input logic [31:0] addr);
        chk({tag, ".req"},  32'(mem_req_o), 32'd1);
        chk({tag, ".addr"}, mem_addr_o, addr);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i    = 1'b0;
        chk({tag, ".wait_noreq"}, 32'(mem_req_o), 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(addr);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'hDEAD_BEEF;
        chk({tag, ".valid"}, 32'(inst_valid_o), 32'd1);
        chk({tag, ".inst"},  inst_o, mem_word(addr));
        chk({tag, ".pc"},    inst_pc_o, addr);
    endtask

    initial begin
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        tick();
        tick();
        chk("rst.req",   32'(mem_req_o), 32'd0);
        chk("rst.valid", 32'(inst_valid_o), 32'd0);
        chk("rst.inst",  inst_o, 32'd0);
        chk("rst.pc",    inst_pc_o, 32'd0);
        chk("rst.addr",  mem_addr_o, 32'h100);

        // 1: boot, three zero-wait fetches
        rst = 1'b0;
        chk("boot.noreq", 32'(mem_req_o), 32'd0);
        tick();
        serve("f100", 32'h100);
        tick();
        serve("f104", 32'h104);
        tick();
        serve("f108", 32'h108);

        // 2: stall in VALID for 5 cycles
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall.valid", 32'(inst_valid_o), 32'd1);
            chk("stall.inst",  inst_o, mem_word(32'h108));
            chk("stall.pc",    inst_pc_o, 32'h108);
            chk("stall.noreq", 32'(mem_req_o), 32'd0);
        end
        stall_i = 1'b0;
        tick();
        chk("unstall.req",   32'(mem_req_o), 32'd1);
        chk("unstall.addr",  mem_addr_o, 32'h10C);
        chk("unstall.valid", 32'(inst_valid_o), 32'd0);

        // 3: grant delayed 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gdly.req",  32'(mem_req_o), 32'd1);
            chk("gdly.addr", mem_addr_o, 32'h10C);
        end
        serve("f10c", 32'h10C);

        // 4: redirect in WAIT, stale response two cycles later
        tick();
        chk("r4.addr", mem_addr_o, 32'h110);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i     = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h2002;
        tick();
        redirect_i = 1'b0;
        chk("r4.noreq",  32'(mem_req_o), 32'd0);
        chk("r4.novalid", 32'(inst_valid_o), 32'd0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0BAD_0BAD;
        tick();
        mem_rvalid_i = 1'b0;
        chk("r4.discard", 32'(inst_valid_o), 32'd0);
        serve("f2000", 32'h2000);

        // 5a: redirect coincident with rvalid
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b1;
        mem_rdata_i   = 32'h0BAD_1111;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h3000;
        tick();
        mem_rvalid_i = 1'b0;
        redirect_i   = 1'b0;
        chk("r5a.novalid", 32'(inst_valid_o), 32'd0);
        serve("f3000", 32'h3000);

        // 5b: redirect in VALID while stalled
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h4000;
        tick();
        redirect_i = 1'b0;
        chk("r5b.novalid", 32'(inst_valid_o), 32'd0);
        serve("f4000", 32'h4000);

        // 6: wrap past the top of the address space (target bits [1:0] masked)
        stall_i       = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        redirect_i = 1'b0;
        serve("ffffc", 32'hFFFF_FFFC);
        tick();
        chk("wrap.req",  32'(mem_req_o), 32'd1);
        chk("wrap.addr", mem_addr_o, 32'h0);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;

        // Async reset mid-WAIT: outputs clear before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("arst.inst",  inst_o, 32'd0);
        chk("arst.pc",    inst_pc_o, 32'd0);
        chk("arst.addr",  mem_addr_o, 32'h100);
        chk("arst.req",   32'(mem_req_o), 32'd0);
        chk("arst.valid", 32'(inst_valid_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        serve("reboot", 32'h100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the instruction-fetch PC and drives the instruction-memory request/response handshake for the fetch stage.
- Holds the architectural fetch PC.
- Issues one memory request at a time.
- Tracks the single outstanding response and squashes it after a branch/jump redirect.
- Presents a valid/stall-held instruction packet (instruction + PC) to decode.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
BOOT_ADDR, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
stall_i  input  1  decode cannot accept; hold current instruction packet
redirect_i  input  1  branch/jump taken; restart fetch at redirect_pc_i
redirect_pc_i  input  XLEN  redirect target; bits [1:0] ignored (forced 0)
mem_req_o  output  1  fetch request valid
mem_addr_o  output  XLEN  fetch address, word aligned
mem_gnt_i  input  1  memory accepted request this cycle
mem_rvalid_i  input  1  read data valid for the outstanding request
mem_rdata_i  input  ILEN  fetched instruction word
inst_valid_o  output  1  inst_o/inst_pc_o valid
inst_o  output  ILEN  fetched instruction
inst_pc_o  output  XLEN  PC of inst_o

Behaviour:
- Reset (async, any state):
  - state=BOOT, pc=BOOT_ADDR, kill=0.
  - mem_req_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
  - Any in-flight memory response after reset is undefined and is not consumed.
- States: BOOT, REQ, WAIT, VALID. At most one outstanding request.
- BOOT: one cycle, then go to REQ.
- REQ:
  - mem_req_o=1, mem_addr_o=pc.
  - On mem_gnt_i: latch req_pc=pc, go to WAIT.
  - Otherwise stay in REQ; the address is held stable.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i with kill=0: inst_o<=mem_rdata_i, inst_pc_o<=req_pc, inst_valid_o<=1, pc<=req_pc+4, go to VALID.
  - On mem_rvalid_i with kill=1: discard data, kill<=0, go to REQ. pc already holds the redirect target.
- VALID:
  - inst_valid_o=1; inst_o and inst_pc_o are held stable while stall_i=1.
  - On stall_i=0 the packet is consumed: inst_valid_o<=0, go to REQ.
- Redirect (redirect_i=1) overrides normal transitions. Only rst has higher priority. It always sets pc<={redirect_pc_i[XLEN-1:2],2'b00} and inst_valid_o<=0. Next state depends on current state:
  - BOOT: go to REQ.
  - REQ without gnt: stay in REQ; the new address appears next cycle. Withdrawing an ungranted address is legal.
  - REQ with gnt in the same cycle: kill<=1, go to WAIT.
  - WAIT without rvalid: kill<=1, stay in WAIT.
  - WAIT with rvalid in the same cycle: discard data, go to REQ.
  - VALID: drop packet regardless of stall_i, go to REQ.
- stall_i has no effect in BOOT, REQ or WAIT. Fetch proceeds and the packet waits in VALID.
- PC arithmetic: pc+4 is modulo 2^XLEN, so 0xFFFF_FFFC+4 = 0x0000_0000.
- Latency with gnt in REQ cycle n and rvalid in cycle n+1: inst_valid_o=1 from cycle n+2. Steady unstalled throughput is one instruction per 3 cycles.
- mem_rvalid_i outside WAIT is ignored.

Test Plan:
1. Reset release, BOOT_ADDR=0x100, memory with zero wait states. Required: first mem_req_o with addr 0x100 the cycle after BOOT; packets with inst_pc_o 0x100, 0x104, 0x108 in order; inst_o matches memory contents.
2. stall_i=1 for 5 cycles while in VALID. Required: inst_valid_o, inst_o and inst_pc_o are constant; no mem_req_o. One cycle after stall_i falls, a request to pc+4 issues.
3. mem_gnt_i delayed 3 cycles. Required: mem_req_o=1 and mem_addr_o stable for all 4 cycles; a single transfer is recorded.
4. redirect_i=1 to 0x2002 while in WAIT, rvalid arrives 2 cycles later. Required: response discarded with no inst_valid_o; next request addr 0x2000; next packet inst_pc_o=0x2000.
5. Redirect coincident with mem_rvalid_i, and redirect in VALID with stall_i=1. Required: in both cases the packet is dropped (inst_valid_o=0 next cycle) and fetch resumes at the target.
6. Wrap and reset. pc=0xFFFF_FFFC followed by a fetch: next request addr is 0x0. Assert rst mid-WAIT: outputs clear immediately (async), and fetch restarts at BOOT_ADDR.
